// File: rtl/bkm_slot_pkg.sv
// Shared codes for the BKM option-slot emulation: command bytes, register
// addresses, video value codes and the bus transaction FSM states.
package bkm_slot_pkg;

    // Command bytes seen in the idle state
    localparam logic [7:0] CMD_TOGGLE = 8'hFF;
    localparam logic [7:0] CMD_IRQ    = 8'h02;
    localparam logic [7:0] CMD_INIT   = 8'h10;
    localparam logic [7:0] CMD_ID     = 8'h20;
    localparam logic [7:0] CMD_VIDEO  = 8'h21;
    localparam logic [7:0] CMD_PREP   = 8'h22;
    localparam logic [7:0] CMD_SERIAL = 8'h23;

    // Data bytes understood while in the interrupt state
    localparam logic [7:0] IRQ_EN   = 8'h01;
    localparam logic [7:0] IRQ_DIS  = 8'h00;
    localparam logic [7:0] IRQ_EXIT = 8'hFF;

    // Init register map (0x40..0x43 form one aligned block)
    localparam logic [7:0] INIT_SLOT_NO = 8'h03;
    localparam logic [5:0] INIT_BLOCK   = 6'h10;
    localparam logic [7:0] INIT_REG41   = 8'h41;
    localparam logic [7:0] INIT_INT_SET = 8'h02;

    // Prepare register map
    localparam logic [7:0] PREP_R20      = 8'h20;
    localparam logic [7:0] PREP_R21      = 8'h21;
    localparam logic [7:0] PREP_R22      = 8'h22;
    localparam logic [7:0] PREP_R24      = 8'h24;
    localparam logic [7:0] PREP_STEP     = 8'h26;
    localparam logic [7:0] PREP_DATA     = 8'h27;
    localparam logic [7:0] PREP_BUSY     = 8'h28;
    localparam logic [7:0] PREP_STEP_VAL = 8'h01;

    // Video register map and value codes
    localparam logic [7:0] VID_RGB     = 8'h00;
    localparam logic [7:0] VID_OE      = 8'h10;
    localparam logic [7:0] VID_FMT     = 8'h31;
    localparam logic [7:0] VAL_RGB     = 8'h00;
    localparam logic [7:0] VAL_YPBPR   = 8'h04;
    localparam logic [7:0] VAL_VID_OFF = 8'h01;
    localparam logic [7:0] VAL_VID_EXT = 8'h08;
    localparam logic [7:0] VAL_VID_INT = 8'h09;

    // Format codes: 0 means no signal, 4 and above are HD
    localparam logic [7:0] FMT_NONE   = 8'h00;
    localparam logic [7:0] FMT_HD_MIN = 8'h04;

    typedef enum logic [1:0] {ST_IDLE, ST_REG, ST_DATA, ST_IRQ} state_t;

endpackage

// File: rtl/bkm_slot_interface_bus_strobe_sync.sv
// Synchronises the monitor bus into the system clock and turns the bus
// strobe into single-cycle write (rise) and read (fall) pulses. The
// qualifier/data outputs come from the same sample as the strobe.
module bus_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_clk_rw,
    input  logic       bus_ax_d,
    input  logic       bus_r_wx,
    input  logic [7:0] bus_data,
    output logic       ax_d,
    output logic       r_wx,
    output logic [7:0] data,
    output logic       wr_stb,
    output logic       rd_stb
);
    // Bus idles with the strobe high so leaving reset never fakes an edge
    localparam logic [10:0] IDLE_BUS = 11'b100_0000_0000;

    logic [10:0] sync_q [SYNC_STAGES];
    logic [10:0] last_q;

    // Synchroniser chain, one-cycle history and registered edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_BUS;
            last_q <= IDLE_BUS;
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
        end else begin
            sync_q[0] <= {bus_clk_rw, bus_ax_d, bus_r_wx, bus_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            last_q <= sync_q[SYNC_STAGES-1];
            wr_stb <= sync_q[SYNC_STAGES-1][10] & ~last_q[10];
            rd_stb <= ~sync_q[SYNC_STAGES-1][10] & last_q[10];
        end
    end

    assign ax_d = last_q[9];
    assign r_wx = last_q[8];
    assign data = last_q[7:0];

endmodule

// File: rtl/bkm_slot_interface.sv
// BKM option-slot card emulation: decodes monitor command bytes and serves
// the init, ID, serial, prepare and video-control registers, driving the
// video routing pins. Everything runs on clk_20mhz.
module bkm_slot_interface
    import bkm_slot_pkg::*;
#(
    parameter logic [7:0]              ID_BYTE         = 8'h88,
    parameter int                      SERIAL_LEN      = 7,
    parameter logic [8*SERIAL_LEN-1:0] SERIAL_STR      = {"555", "000", "2"},
    parameter int                      SERIAL_UNLOCK   = 7,
    parameter int                      PREP_BUSY_READS = 9,
    parameter int                      SYNC_STAGES     = 2
) (
    input  logic       clk_20mhz,
    input  logic       reset_x,
    input  logic       slot_x_int_x,
    input  logic       clk_rw,
    input  logic       ax_d,
    input  logic       r_wx,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe_x,
    output logic       int_x,
    output logic       int_oe_x,
    output logic       video_oe_x,
    output logic       rgb_comp_x,
    output logic       int_ext_x,
    output logic       hd_sd_x
);
    localparam logic [127:0] SERIAL_PAD = 128'(SERIAL_STR);
    localparam logic [3:0]   UNLOCK     = 4'(SERIAL_UNLOCK);
    localparam logic [7:0]   SLEN       = 8'(SERIAL_LEN);
    localparam logic [7:0]   BUSY_DEF   = 8'(PREP_BUSY_READS);

    logic       s_ax_d, s_r_wx, wr_stb, rd_stb;
    logic [7:0] s_data;
    logic [1:0] slot_sync_q;
    state_t     state_q, state_d;
    logic       cmd_ok, selected_q, drv_en_q;
    logic [7:0] cmd_q, reg_addr_q, rd_val;
    logic [7:0] init_q [4];
    logic [7:0] slot_no_q, prep20_q, prep21_q, prep22_q, prep24_q;
    logic [7:0] busy_cfg_q, prep27_q, busy_cnt_q, fmt_q;
    logic [3:0] prep_cnt_q;
    logic       write_en, prep_read27;

    bus_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk_20mhz), .rst_n(reset_x),
        .bus_clk_rw(clk_rw), .bus_ax_d(ax_d), .bus_r_wx(r_wx), .bus_data(data_in),
        .ax_d(s_ax_d), .r_wx(s_r_wx), .data(s_data), .wr_stb(wr_stb), .rd_stb(rd_stb)
    );

    // Slot-select is static during a command but still crosses into clk_20mhz
    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) slot_sync_q <= 2'b11;
        else          slot_sync_q <= {slot_sync_q[0], slot_x_int_x};
    end

    // FSM state register
    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; every transition is taken on a write strobe
    always_comb begin
        state_d = state_q;
        cmd_ok  = 1'b0;
        if (wr_stb) begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ok = (s_data == CMD_INIT && !slot_sync_q[1]) ||
                             ((s_data inside {CMD_ID, CMD_VIDEO, CMD_PREP, CMD_SERIAL}) && selected_q);
                    if (s_data == CMD_IRQ) state_d = ST_IRQ;
                    else if (cmd_ok)       state_d = ST_REG;
                end
                ST_REG:  state_d = ST_DATA;
                ST_DATA: state_d = ST_IDLE;
                ST_IRQ:  if (s_ax_d && s_data == IRQ_EXIT) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign write_en    = wr_stb && state_q == ST_DATA && !s_r_wx;
    assign prep_read27 = rd_stb && s_ax_d && s_r_wx && state_q == ST_DATA &&
                         cmd_q == CMD_PREP && reg_addr_q == PREP_DATA;

    // Selection, driver enable, latched command/address and interrupt enable
    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) begin
            selected_q <= 1'b0;
            drv_en_q   <= 1'b0;
            cmd_q      <= 8'h00;
            reg_addr_q <= 8'h00;
            int_oe_x   <= 1'b0;
        end else if (wr_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (s_data == CMD_TOGGLE) begin
                        selected_q <= ~selected_q;
                        if (selected_q) drv_en_q <= 1'b0;
                    end else if (s_data == CMD_IRQ) begin
                        selected_q <= 1'b1;
                        drv_en_q   <= 1'b1;
                    end else if (cmd_ok) begin
                        cmd_q    <= s_data;
                        drv_en_q <= 1'b1;
                    end
                end
                ST_REG: reg_addr_q <= s_data;
                ST_IRQ: begin
                    if (s_ax_d) begin
                        case (s_data)
                            IRQ_EN:   int_oe_x <= 1'b1;
                            IRQ_DIS:  int_oe_x <= 1'b0;
                            IRQ_EXIT: begin
                                drv_en_q <= 1'b0;
                                if (!int_oe_x) selected_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file writes and the read side effects of prepare reg 0x27
    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) begin
            init_q[0] <= 8'hFF; init_q[1] <= 8'hFD; init_q[2] <= 8'hFF; init_q[3] <= 8'hFD;
            slot_no_q <= 8'h00; int_x <= 1'b0;
            prep20_q <= 8'h00; prep21_q <= 8'h00; prep22_q <= 8'h00; prep24_q <= 8'h00;
            prep_cnt_q <= 4'd0; busy_cfg_q <= BUSY_DEF; prep27_q <= 8'h00; busy_cnt_q <= 8'h00;
            video_oe_x <= 1'b1; rgb_comp_x <= 1'b0; int_ext_x <= 1'b0; fmt_q <= FMT_NONE;
        end else if (write_en) begin
            case (cmd_q)
                CMD_INIT: begin
                    if (reg_addr_q == INIT_REG41 && s_data == INIT_INT_SET) begin
                        int_x     <= 1'b1;
                        init_q[1] <= 8'hFF;
                    end else if (reg_addr_q[7:2] == INIT_BLOCK) begin
                        init_q[reg_addr_q[1:0]] <= s_data;
                    end else if (reg_addr_q == INIT_SLOT_NO) begin
                        slot_no_q <= s_data;
                    end
                end
                CMD_PREP: begin
                    case (reg_addr_q)
                        PREP_R20:  prep20_q <= s_data;
                        PREP_R21:  prep21_q <= s_data;
                        PREP_R22:  prep22_q <= s_data;
                        PREP_R24:  prep24_q <= s_data;
                        PREP_STEP: if (s_data == PREP_STEP_VAL && prep_cnt_q != 4'd15)
                                       prep_cnt_q <= prep_cnt_q + 4'd1;
                        PREP_DATA: begin
                            prep27_q   <= s_data;
                            busy_cnt_q <= busy_cfg_q;
                        end
                        PREP_BUSY: busy_cfg_q <= (s_data == 8'h00) ? BUSY_DEF : s_data;
                        default: ;
                    endcase
                end
                CMD_VIDEO: begin
                    case (reg_addr_q)
                        VID_RGB: begin
                            if (s_data == VAL_RGB)        rgb_comp_x <= 1'b1;
                            else if (s_data == VAL_YPBPR) rgb_comp_x <= 1'b0;
                        end
                        VID_OE: begin
                            if (s_data == VAL_VID_OFF) begin
                                video_oe_x <= 1'b1;
                            end else if (s_data == VAL_VID_EXT || s_data == VAL_VID_INT) begin
                                video_oe_x <= 1'b0;
                                int_ext_x  <= (s_data == VAL_VID_INT);
                            end
                        end
                        VID_FMT: fmt_q <= s_data;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else if (prep_read27) begin
            // The value stays visible for busy_cfg-1 reads, then self-clears
            if (busy_cnt_q > 8'd1) busy_cnt_q <= busy_cnt_q - 8'd1;
            else                   prep27_q   <= 8'h00;
        end
    end

    // Read data selected by the latched command and register address
    always_comb begin
        rd_val = 8'h00;
        case (cmd_q)
            CMD_INIT: begin
                if (reg_addr_q[7:2] == INIT_BLOCK)  rd_val = init_q[reg_addr_q[1:0]];
                else if (reg_addr_q == INIT_SLOT_NO) rd_val = slot_no_q;
            end
            CMD_ID: if (reg_addr_q == 8'h00) rd_val = ID_BYTE;
            CMD_SERIAL: begin
                if (prep_cnt_q < UNLOCK)    rd_val = ID_BYTE;
                else if (reg_addr_q < SLEN) rd_val = SERIAL_PAD[{reg_addr_q[3:0], 3'b000} +: 8];
            end
            CMD_PREP: begin
                case (reg_addr_q)
                    PREP_R20:  rd_val = prep20_q;
                    PREP_R21:  rd_val = prep21_q;
                    PREP_R22:  rd_val = prep22_q;
                    PREP_R24:  rd_val = prep24_q;
                    PREP_STEP: rd_val = {4'h0, prep_cnt_q};
                    PREP_DATA: rd_val = (busy_cnt_q > 8'd1) ? prep27_q : 8'h00;
                    PREP_BUSY: rd_val = busy_cfg_q;
                    default:   rd_val = 8'h00;
                endcase
            end
            CMD_VIDEO: if (reg_addr_q == VID_FMT) rd_val = fmt_q;
            default: rd_val = 8'hFF;
        endcase
    end

    // Read phase loads the bus register; non-read phases park it at 0xFF
    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x)    data_out <= 8'hFF;
        else if (rd_stb) data_out <= (s_ax_d && s_r_wx) ? rd_val : 8'hFF;
    end

    assign data_oe_x = ~(drv_en_q & s_r_wx & s_ax_d);
    assign hd_sd_x   = (fmt_q == FMT_NONE) || (fmt_q >= FMT_HD_MIN);

endmodule

// File: tb/tb_bkm_slot_interface.sv
// Directed bench for bkm_slot_interface: drives monitor bus cycles with
// slow strobes and checks read data and video pins against hand values.
module tb_bkm_slot_interface;

    logic       clk_20mhz = 1'b0;
    logic       reset_x = 1'b0;
    logic       slot_x_int_x = 1'b1;
    logic       clk_rw = 1'b1;
    logic       ax_d = 1'b0;
    logic       r_wx = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe_x, int_x, int_oe_x, video_oe_x, rgb_comp_x, int_ext_x, hd_sd_x;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] rd_byte;
    logic       rd_oe_x;
    logic [7:0] ser_exp [8];

    // Clock: 20 MHz
    always #25 clk_20mhz = ~clk_20mhz;

    bkm_slot_interface dut (
        .clk_20mhz(clk_20mhz), .reset_x(reset_x), .slot_x_int_x(slot_x_int_x),
        .clk_rw(clk_rw), .ax_d(ax_d), .r_wx(r_wx), .data_in(data_in),
        .data_out(data_out), .data_oe_x(data_oe_x), .int_x(int_x), .int_oe_x(int_oe_x),
        .video_oe_x(video_oe_x), .rgb_comp_x(rgb_comp_x), .int_ext_x(int_ext_x),
        .hd_sd_x(hd_sd_x)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus cycle: low phase (read window) then high phase; rd_byte and
    // rd_oe_x are sampled late in the low phase
    task automatic bus_cycle(input logic ax, input logic rw, input logic [7:0] din);
        @(negedge clk_20mhz);
        ax_d = ax; r_wx = rw; data_in = din; clk_rw = 1'b0;
        repeat (6) @(negedge clk_20mhz);
        rd_byte = data_out;
        rd_oe_x = data_oe_x;
        clk_rw = 1'b1;
        repeat (6) @(negedge clk_20mhz);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        bus_cycle(1'b0, 1'b0, b);
    endtask

    task automatic reg_write(input logic [7:0] c, input logic [7:0] a, input logic [7:0] v);
        bus_cycle(1'b0, 1'b0, c);
        bus_cycle(1'b0, 1'b0, a);
        bus_cycle(1'b1, 1'b0, v);
    endtask

    task automatic reg_read(input logic [7:0] c, input logic [7:0] a);
        bus_cycle(1'b0, 1'b0, c);
        bus_cycle(1'b0, 1'b0, a);
        bus_cycle(1'b1, 1'b1, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data_out"}, data_out, 8'hFF);
        check_eq({tag, "_data_oe_x"}, data_oe_x, 1'b1);
        check_eq({tag, "_int_x"}, int_x, 1'b0);
        check_eq({tag, "_int_oe_x"}, int_oe_x, 1'b0);
        check_eq({tag, "_video_oe_x"}, video_oe_x, 1'b1);
        check_eq({tag, "_rgb_comp_x"}, rgb_comp_x, 1'b0);
        check_eq({tag, "_int_ext_x"}, int_ext_x, 1'b0);
        check_eq({tag, "_hd_sd_x"}, hd_sd_x, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk_20mhz);
        reset_x = 1'b0; clk_rw = 1'b1; ax_d = 1'b0; r_wx = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge clk_20mhz);
        reset_x = 1'b1;
        repeat (3) @(negedge clk_20mhz);
    endtask

    initial begin
        ser_exp = '{8'h32, 8'h30, 8'h30, 8'h30, 8'h35, 8'h35, 8'h35, 8'h00};

        // Reset values and ID read
        repeat (3) @(negedge clk_20mhz);
        check_reset_outputs("por");
        reset_x = 1'b1;
        repeat (3) @(negedge clk_20mhz);
        send_cmd(8'hFF);
        reg_read(8'h20, 8'h00);
        check_eq("id_data", rd_byte, 8'h88);
        check_eq("id_oe", rd_oe_x, 1'b0);
        reg_read(8'h20, 8'h05);
        check_eq("id_other_addr", rd_byte, 8'h00);

        // Prepare busy reads: 8 reads of the value then 0x00
        do_reset();
        send_cmd(8'hFF);
        reg_write(8'h22, 8'h27, 8'h09);
        for (int i = 0; i < 10; i++) begin
            reg_read(8'h22, 8'h27);
            check_eq($sformatf("busy_read%0d", i), rd_byte, (i < 8) ? 8'h09 : 8'h00);
        end
        // Shorter busy configuration, then reg 0x24 read/write
        reg_write(8'h22, 8'h28, 8'h03);
        reg_write(8'h22, 8'h27, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            reg_read(8'h22, 8'h27);
            check_eq($sformatf("busy3_read%0d", i), rd_byte, (i < 2) ? 8'h5A : 8'h00);
        end
        reg_write(8'h22, 8'h24, 8'hA5);
        reg_read(8'h22, 8'h24);
        check_eq("prep_r24", rd_byte, 8'hA5);

        // Serial: locked at 6 prepare steps, unlocked at 7
        do_reset();
        send_cmd(8'hFF);
        for (int i = 0; i < 6; i++) reg_write(8'h22, 8'h26, 8'h01);
        reg_read(8'h23, 8'h00);
        check_eq("serial_locked0", rd_byte, 8'h88);
        reg_read(8'h23, 8'h04);
        check_eq("serial_locked4", rd_byte, 8'h88);
        reg_write(8'h22, 8'h26, 8'h01);
        for (int i = 0; i < 8; i++) begin
            reg_read(8'h23, 8'(i));
            check_eq($sformatf("serial_byte%0d", i), rd_byte, ser_exp[i]);
        end

        // Video control
        do_reset();
        send_cmd(8'hFF);
        reg_write(8'h21, 8'h10, 8'h09);
        reg_write(8'h21, 8'h00, 8'h00);
        reg_write(8'h21, 8'h31, 8'h02);
        check_eq("vid_oe_on", video_oe_x, 1'b0);
        check_eq("vid_int_src", int_ext_x, 1'b1);
        check_eq("vid_rgb", rgb_comp_x, 1'b1);
        check_eq("vid_sd", hd_sd_x, 1'b0);
        reg_write(8'h21, 8'h31, 8'h04);
        check_eq("vid_hd_fmt4", hd_sd_x, 1'b1);
        reg_read(8'h21, 8'h31);
        check_eq("vid_fmt_read", rd_byte, 8'h04);
        reg_write(8'h21, 8'h31, 8'h03);
        check_eq("vid_sd_fmt3", hd_sd_x, 1'b0);
        reg_write(8'h21, 8'h10, 8'h05);
        check_eq("vid_ignored_oe", video_oe_x, 1'b0);
        reg_write(8'h21, 8'h10, 8'h08);
        check_eq("vid_ext_src", int_ext_x, 1'b0);
        reg_write(8'h21, 8'h00, 8'h04);
        check_eq("vid_ypbpr", rgb_comp_x, 1'b0);
        reg_write(8'h21, 8'h10, 8'h01);
        check_eq("vid_oe_off", video_oe_x, 1'b1);

        // Init command with slot select low
        do_reset();
        slot_x_int_x = 1'b0;
        reg_write(8'h10, 8'h41, 8'h02);
        check_eq("init_int_x", int_x, 1'b1);
        reg_read(8'h10, 8'h41);
        check_eq("init_reg41", rd_byte, 8'hFF);
        reg_read(8'h10, 8'h43);
        check_eq("init_reg43", rd_byte, 8'hFD);
        reg_write(8'h10, 8'h40, 8'h5A);
        reg_read(8'h10, 8'h40);
        check_eq("init_reg40", rd_byte, 8'h5A);
        // Same command with slot select high is ignored
        do_reset();
        slot_x_int_x = 1'b1;
        send_cmd(8'h10);
        bus_cycle(1'b1, 1'b1, 8'h00);
        check_eq("init_ignored_oe", rd_oe_x, 1'b1);

        // Interrupt state
        do_reset();
        send_cmd(8'h02);
        bus_cycle(1'b1, 1'b0, 8'h01);
        check_eq("irq_oe_set", int_oe_x, 1'b1);
        bus_cycle(1'b1, 1'b0, 8'h00);
        check_eq("irq_oe_clr", int_oe_x, 1'b0);
        bus_cycle(1'b1, 1'b0, 8'h01);
        bus_cycle(1'b1, 1'b0, 8'hFF);
        reg_read(8'h20, 8'h00);
        check_eq("irq_exit_keep_sel", rd_byte, 8'h88);
        do_reset();
        send_cmd(8'h02);
        bus_cycle(1'b1, 1'b0, 8'hFF);
        send_cmd(8'h20);
        send_cmd(8'h00);
        bus_cycle(1'b1, 1'b1, 8'h00);
        check_eq("irq_exit_desel_oe", rd_oe_x, 1'b1);

        // Reset in the middle of a prepare read burst
        do_reset();
        send_cmd(8'hFF);
        reg_write(8'h21, 8'h10, 8'h09);
        reg_write(8'h22, 8'h27, 8'h09);
        for (int i = 0; i < 3; i++) begin
            reg_read(8'h22, 8'h27);
            check_eq($sformatf("burst_read%0d", i), rd_byte, 8'h09);
        end
        @(negedge clk_20mhz);
        reset_x = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk_20mhz);
        reset_x = 1'b1;
        repeat (3) @(negedge clk_20mhz);
        send_cmd(8'hFF);
        reg_read(8'h20, 8'h00);
        check_eq("post_reset_id", rd_byte, 8'h88);
        reg_read(8'h22, 8'h27);
        check_eq("post_reset_prep27", rd_byte, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
